sdram_aref_sched: RTL and testbench

- Parametrised AUTO-REFRESH scheduler for the SDRAM controller, successor to the single-row refresh block.
- Tracks the refresh interval and accumulates a saturating count of owed refreshes (debt). It requests the arbiter and, on grant, issues one PRECHARGE-all followed by a burst of back-to-back AUTO-REFRESH commands.
- Sits between the init sequencer (init_done) and the command arbiter.
- Adds postponement, urgency and overflow reporting, which the single-row block lacks.

---
 rtl/sdram_aref_sched.sv | 188 ++++++++++++++++++
 tb/tb_sdram_aref_sched.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_aref_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : sdram_aref_sched                                              |
// | Function : SDRAM auto-refresh scheduler with refresh debt accounting.    |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module sdram_aref_sched #(
    parameter int ADDR_BITS    = 12,
    parameter int T_REFI       = 2000,
    parameter int T_RP         = 3,
    parameter int T_RFC        = 9,
    parameter int MAX_DEBT     = 8,
    parameter int URGENT_LEVEL = 6,
    parameter int MAX_BURST    = 4,
    parameter int DEBT_W       = 4
) (
    input  logic                 sdram_clk,
    input  logic                 rst,
    input  logic                 init_done,
    input  logic                 aref_en,
    output logic                 aref_req,
    output logic                 aref_urgent,
    output logic                 aref_busy,
    output logic                 aref_done,
    output logic                 aref_overflow,
    output logic [DEBT_W-1:0]    aref_debt,
    output logic [3:0]           aref_cmd,
    output logic [ADDR_BITS-1:0] sdram_addr
);

    localparam int c_REFI_W  = (T_REFI > 1) ? $clog2(T_REFI) : 1;
    localparam int c_WAIT_MX = (T_RP > T_RFC) ? T_RP : T_RFC;
    localparam int c_WAIT_W  = $clog2(c_WAIT_MX + 1);
    localparam int c_BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [c_REFI_W-1:0]  c_REFI_LAST = c_REFI_W'(T_REFI - 1);
    localparam logic [c_WAIT_W-1:0]  c_RP_WAIT   = c_WAIT_W'((T_RP > 1) ? T_RP - 2 : 0);
    localparam logic [c_WAIT_W-1:0]  c_RFC_WAIT  = c_WAIT_W'((T_RFC > 1) ? T_RFC - 2 : 0);
    localparam logic [DEBT_W-1:0]    c_MAX_DEBT  = DEBT_W'(MAX_DEBT);
    localparam logic [DEBT_W-1:0]    c_URGENT    = DEBT_W'(URGENT_LEVEL);
    localparam logic [c_BURST_W-1:0] c_MAX_BURST = c_BURST_W'(MAX_BURST);

    localparam logic [3:0] c_CMD_NOP  = 4'b0111;
    localparam logic [3:0] c_CMD_PRE  = 4'b0010;
    localparam logic [3:0] c_CMD_AREF = 4'b0001;

    localparam logic [2:0] c_ST_IDLE     = 3'd0;
    localparam logic [2:0] c_ST_PRE      = 3'd1;
    localparam logic [2:0] c_ST_WAIT_RP  = 3'd2;
    localparam logic [2:0] c_ST_AREF     = 3'd3;
    localparam logic [2:0] c_ST_WAIT_RFC = 3'd4;
    localparam logic [2:0] c_ST_DONE     = 3'd5;

    logic [2:0]           state_q,    state_d;
    logic [c_REFI_W-1:0]  refi_cnt_q, refi_cnt_d;
    logic [DEBT_W-1:0]    debt_q,     debt_d;
    logic                 ovf_q,      ovf_d;
    logic [c_WAIT_W-1:0]  wait_q,     wait_d;
    logic [c_BURST_W-1:0] burst_q,    burst_d;

    logic w_tick;
    logic w_aref_issue;
    logic w_req;

    assign w_tick       = init_done && (refi_cnt_q == c_REFI_LAST);
    assign w_aref_issue = (state_q == c_ST_AREF);
    assign w_req        = (state_q == c_ST_IDLE) && (debt_q != '0) && init_done;

    always_ff @(posedge sdram_clk) begin
        if (rst) begin
            state_q    <= c_ST_IDLE;
            refi_cnt_q <= '0;
            debt_q     <= '0;
            ovf_q      <= 1'b0;
            wait_q     <= '0;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            refi_cnt_q <= refi_cnt_d;
            debt_q     <= debt_d;
            ovf_q      <= ovf_d;
            wait_q     <= wait_d;
            burst_q    <= burst_d;
        end
    end

    // Interval counter and debt; a tick landing on an AREF cancels out.
    always_comb begin
        refi_cnt_d = '0;
        if (init_done && !w_tick) begin
            refi_cnt_d = refi_cnt_q + 1'b1;
        end
        debt_d = debt_q;
        ovf_d  = ovf_q;
        if (w_tick && !w_aref_issue) begin
            if (debt_q < c_MAX_DEBT) begin
                debt_d = debt_q + 1'b1;
            end else begin
                ovf_d = 1'b1;
            end
        end else if (w_aref_issue && !w_tick && (debt_q != '0)) begin
            debt_d = debt_q - 1'b1;
        end
    end

    // Burst continuation looks at next-cycle debt so late ticks are counted.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        burst_d = burst_q;
        case (state_q)
            c_ST_IDLE: begin
                burst_d = '0;
                if (aref_en && w_req) begin
                    state_d = c_ST_PRE;
                end
            end
            c_ST_PRE: begin
                if (T_RP > 1) begin
                    state_d = c_ST_WAIT_RP;
                    wait_d  = c_RP_WAIT;
                end else begin
                    state_d = c_ST_AREF;
                end
            end
            c_ST_WAIT_RP: begin
                if (wait_q == '0) begin
                    state_d = c_ST_AREF;
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            c_ST_AREF: begin
                burst_d = burst_q + 1'b1;
                if (T_RFC > 1) begin
                    state_d = c_ST_WAIT_RFC;
                    wait_d  = c_RFC_WAIT;
                end else if ((debt_d != '0) && (burst_d < c_MAX_BURST)) begin
                    state_d = c_ST_AREF;
                end else begin
                    state_d = c_ST_DONE;
                end
            end
            c_ST_WAIT_RFC: begin
                if (wait_q == '0) begin
                    if ((debt_d != '0) && (burst_q < c_MAX_BURST)) begin
                        state_d = c_ST_AREF;
                    end else begin
                        state_d = c_ST_DONE;
                    end
                end else begin
                    wait_d = wait_q - 1'b1;
                end
            end
            c_ST_DONE: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_comb begin
        aref_cmd   = c_CMD_NOP;
        sdram_addr = '0;
        case (state_q)
            c_ST_PRE: begin
                aref_cmd       = c_CMD_PRE;
                sdram_addr[10] = 1'b1;
            end
            c_ST_AREF: begin
                aref_cmd = c_CMD_AREF;
            end
            default: begin
                aref_cmd = c_CMD_NOP;
            end
        endcase
        aref_done     = (state_q == c_ST_DONE);
        aref_busy     = (state_q != c_ST_IDLE);
        aref_req      = w_req;
        aref_urgent   = (debt_q >= c_URGENT);
        aref_overflow = ovf_q;
        aref_debt     = debt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_aref_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_sdram_aref_sched                                           |
// | Function : Directed bench with a timeline model of the refresh schedule. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_sdram_aref_sched;

    localparam int c_T_RP      = 3;
    localparam int c_T_RFC     = 9;
    localparam int c_MAX_DEBT  = 8;
    localparam int c_URGENT    = 6;
    localparam int c_MAX_BURST = 4;

    // pos counts cycles since the grant (0 = idle); AREFs land on next_aref.
    typedef struct {
        int cnt;
        int debt;
        bit ovf;
        int pos;
        int next_aref;
        int arefs;
        int done_pos;
    } mdl_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, init_a, en_a, rst_b, init_b, en_b;
    logic req_a, urg_a, busy_a, done_a, ovf_a;
    logic req_b, urg_b, busy_b, done_b, ovf_b;
    logic [3:0]  debt_a, debt_b, cmd_a, cmd_b;
    logic [11:0] addr_a, addr_b;

    int   checks = 0;
    int   errors = 0;
    bit   armed  = 1'b0;
    mdl_t ma = '{default: 0};
    mdl_t mb = '{default: 0};

    sdram_aref_sched #(.T_REFI(20)) dut_a (
        .sdram_clk(clk), .rst(rst_a), .init_done(init_a), .aref_en(en_a),
        .aref_req(req_a), .aref_urgent(urg_a), .aref_busy(busy_a),
        .aref_done(done_a), .aref_overflow(ovf_a), .aref_debt(debt_a),
        .aref_cmd(cmd_a), .sdram_addr(addr_a)
    );

    sdram_aref_sched #(.T_REFI(10)) dut_b (
        .sdram_clk(clk), .rst(rst_b), .init_done(init_b), .aref_en(en_b),
        .aref_req(req_b), .aref_urgent(urg_b), .aref_busy(busy_b),
        .aref_done(done_b), .aref_overflow(ovf_b), .aref_debt(debt_b),
        .aref_cmd(cmd_b), .sdram_addr(addr_b)
    );

    function automatic bit m_aref(input mdl_t m);
        return (m.pos != 0) && (m.pos == m.next_aref);
    endfunction

    function automatic bit m_done(input mdl_t m);
        return (m.pos != 0) && (m.pos == m.done_pos);
    endfunction

    function automatic bit m_req(input mdl_t m, input logic init);
        return (m.pos == 0) && (m.debt != 0) && (init == 1'b1);
    endfunction

    function automatic int m_cmd(input mdl_t m);
        if (m.pos == 1) return 4'b0010;
        if (m_aref(m))  return 4'b0001;
        return 4'b0111;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input logic r, input logic init,
                                      input logic en, input int trefi);
        mdl_t n;
        bit   tick;
        bit   aref;
        n = m;
        if (r) begin
            n = '{default: 0};
            return n;
        end
        tick  = init && (m.cnt == trefi - 1);
        n.cnt = (!init || tick) ? 0 : m.cnt + 1;
        aref  = m_aref(m);
        if (tick && !aref) begin
            if (m.debt < c_MAX_DEBT) n.debt = m.debt + 1;
            else                     n.ovf  = 1'b1;
        end else if (aref && !tick) begin
            n.debt = m.debt - 1;
        end
        if (m.pos == 0) begin
            if (en && m_req(m, init)) begin
                n.pos       = 1;
                n.next_aref = 1 + c_T_RP;
                n.arefs     = 0;
                n.done_pos  = 0;
            end
        end else if (m_done(m)) begin
            n.pos = 0;
        end else begin
            if (aref) begin
                n.arefs     = m.arefs + 1;
                n.next_aref = m.next_aref + c_T_RFC;
            end else if (m.arefs > 0 && m.pos == m.next_aref - 1) begin
                if (!(n.debt != 0 && m.arefs < c_MAX_BURST)) begin
                    n.done_pos  = m.pos + 1;
                    n.next_aref = 0;
                end
            end
            n.pos = m.pos + 1;
        end
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        ma <= mdl_step(ma, rst_a, init_a, en_a, 20);
        mb <= mdl_step(mb, rst_b, init_b, en_b, 10);
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("a_cmd",    int'(cmd_a),  m_cmd(ma));
            chk("a_addr",   int'(addr_a), (ma.pos == 1) ? 32'h400 : 0);
            chk("a_req",    int'(req_a),  int'(m_req(ma, init_a)));
            chk("a_urgent", int'(urg_a),  int'(ma.debt >= c_URGENT));
            chk("a_busy",   int'(busy_a), int'(ma.pos != 0));
            chk("a_done",   int'(done_a), int'(m_done(ma)));
            chk("a_ovf",    int'(ovf_a),  int'(ma.ovf));
            chk("a_debt",   int'(debt_a), ma.debt);
            chk("b_cmd",    int'(cmd_b),  m_cmd(mb));
            chk("b_req",    int'(req_b),  int'(m_req(mb, init_b)));
            chk("b_busy",   int'(busy_b), int'(mb.pos != 0));
            chk("b_done",   int'(done_b), int'(m_done(mb)));
            chk("b_debt",   int'(debt_b), mb.debt);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_a = 1'b1; init_a = 1'b0; en_a = 1'b0;
        rst_b = 1'b1; init_b = 1'b0; en_b = 1'b0;
        repeat (3) cyc();
        armed = 1'b1;
        chk("reset_cmd",  int'(cmd_a),  7);
        chk("reset_debt", int'(debt_a), 0);
        chk("reset_busy", int'(busy_a), 0);

        // Stray grant with no debt, then first tick after 20 cycles.
        rst_a = 1'b0; init_a = 1'b1; en_a = 1'b1;
        cyc();
        en_a = 1'b0;
        chk("stray_en_cmd",  int'(cmd_a),  7);
        chk("stray_en_busy", int'(busy_a), 0);
        repeat (18) cyc();
        chk("pre_tick_debt", int'(debt_a), 0);
        cyc();
        chk("first_tick_debt", int'(debt_a), 1);
        chk("first_tick_req",  int'(req_a),  1);

        en_a = 1'b1;
        cyc();
        en_a = 1'b0;
        chk("pre_cmd",   int'(cmd_a),  2);
        chk("pre_addr",  int'(addr_a), 32'h400);
        chk("pre_req",   int'(req_a),  0);
        repeat (3) cyc();
        chk("aref_cmd",  int'(cmd_a),  1);
        chk("aref_addr", int'(addr_a), 0);
        repeat (9) cyc();
        chk("done_pulse", int'(done_a), 1);
        chk("done_cmd",   int'(cmd_a),  7);
        cyc();
        chk("after_debt", int'(debt_a), 0);
        chk("after_busy", int'(busy_a), 0);

        // Urgency, then a capped burst with init_done dropped mid-sequence.
        n = 0;
        while (ma.debt != 5 && n < 300) begin cyc(); n++; end
        chk("wait_debt5", ma.debt, 5);
        chk("urgent_at5", int'(urg_a), 0);
        n = 0;
        while (ma.debt != 6 && n < 300) begin cyc(); n++; end
        chk("wait_debt6", ma.debt, 6);
        chk("urgent_at6", int'(urg_a), 1);
        en_a = 1'b1;
        cyc();
        en_a = 1'b0; init_a = 1'b0;
        repeat (4) cyc();
        en_a = 1'b1;
        cyc();
        en_a = 1'b0;
        repeat (24) cyc();
        init_a = 1'b1;
        repeat (10) cyc();
        chk("burst_done", int'(done_a), 1);
        chk("burst_debt", int'(debt_a), 2);
        cyc();
        chk("rereq", int'(req_a), 1);

        // Saturation and sticky overflow.
        n = 0;
        while (!ma.ovf && n < 400) begin cyc(); n++; end
        chk("wait_ovf",  int'(ma.ovf), 1);
        chk("ovf_set",   int'(ovf_a),  1);
        chk("ovf_debt",  int'(debt_a), 8);
        en_a = 1'b1;
        cyc();
        en_a = 1'b0;
        repeat (39) cyc();
        chk("ovf_burst_done", int'(done_a), 1);
        chk("ovf_sticky",     int'(ovf_a),  1);
        chk("ovf_burst_debt", int'(debt_a), 6);
        cyc();
        chk("ovf_rereq", int'(req_a), 1);

        // Reset during WAIT_RFC.
        en_a = 1'b1;
        cyc();
        en_a = 1'b0;
        repeat (5) cyc();
        chk("rfc_busy", int'(busy_a), 1);
        rst_a = 1'b1;
        cyc();
        rst_a = 1'b0;
        chk("rst_cmd",    int'(cmd_a),  7);
        chk("rst_busy",   int'(busy_a), 0);
        chk("rst_debt",   int'(debt_a), 0);
        chk("rst_ovf",    int'(ovf_a),  0);
        chk("rst_urgent", int'(urg_a),  0);
        chk("rst_done",   int'(done_a), 0);

        // T_REFI = 10: tick coincides with the first AREF.
        rst_b = 1'b0; init_b = 1'b1;
        repeat (10) cyc();
        chk("b_first_debt", int'(debt_b), 1);
        repeat (5) cyc();
        en_b = 1'b1;
        cyc();
        en_b = 1'b0;
        repeat (3) cyc();
        chk("b_aref1",      int'(cmd_b),  1);
        cyc();
        chk("b_debt_kept",  int'(debt_b), 1);
        repeat (8) cyc();
        chk("b_aref2",      int'(cmd_b),  1);
        cyc();
        chk("b_debt_after2", int'(debt_b), 0);
        n = 0;
        while (mb.pos != 0 && n < 100) begin cyc(); n++; end
        chk("b_wait_idle", mb.pos, 0);
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
